// File: rtl/alu_acc_seq.sv
// Accumulator sequencer wrapped around an external 8-bit ripple add/sub unit.
// It accepts one command at a time and returns a result and {C,Z,N,V} flags.
module alu_acc_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic [3:0]       rsp_flags_q;
    logic             rsp_valid_q;
    logic             cmd_ready_q;

    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] acc_d;
    logic [3:0]       flags_d;
    logic             c_d;
    logic             v_d;
    logic             a_msb;
    logic             b_msb;
    logic             s_msb;

    // The unit only ever sees registered operands, so its inputs are stable
    // for the whole EXEC cycle and quiet (all zero) while in reset.
    assign add_a   = acc_q;
    assign add_b   = data_q;
    assign add_cin = op_q[1];

    assign a_msb = acc_q[WIDTH-1];
    assign b_msb = data_q[WIDTH-1];
    assign s_msb = add_s[WIDTH-1];

    // Overflow uses the un-inverted b, so SUB/CMP test for differing signs.
    always_comb begin
        result_d = add_s;
        acc_d    = add_s;
        c_d      = add_cout;
        v_d      = 1'b0;
        case (op_q)
            OP_LOAD: begin
                result_d = data_q;
                acc_d    = data_q;
                c_d      = 1'b0;
                v_d      = 1'b0;
            end
            OP_ADD: begin
                v_d = (a_msb == b_msb) && (s_msb != a_msb);
            end
            OP_SUB: begin
                v_d = (a_msb != b_msb) && (s_msb != a_msb);
            end
            OP_CMP: begin
                v_d   = (a_msb != b_msb) && (s_msb != a_msb);
                acc_d = acc_q;
            end
            default: begin
                v_d = 1'b0;
            end
        endcase
        flags_d = {c_d, (result_d == '0), result_d[WIDTH-1], v_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            acc_q       <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        data_q      <= cmd_data;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= result_d;
                    rsp_flags_q <= flags_d;
                    acc_q       <= acc_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed bench for alu_acc_seq; a behavioural add/sub unit closes the loop
// around the sequencer, and expected results are hand-computed constants.
module tb_alu_acc_seq;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic [7:0] acc_out;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_s;
    logic       add_cout;
    logic [8:0] sum9;

    int tests;
    int fails;

    alu_acc_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .acc_out   (acc_out),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // External ripple add/sub unit: b is inverted internally when cin=1.
    assign sum9     = {1'b0, add_a} + {1'b0, (add_cin ? ~add_b : add_b)} + {8'd0, add_cin};
    assign add_s    = sum9[7:0];
    assign add_cout = sum9[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cmd_ready(input string name);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: cmd_ready timeout got=%b want=1", name, cmd_ready);
        end
    endtask

    // Issue one command, check EXEC-cycle adder drive, the response, then consume it.
    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] data,
                          input logic [7:0] exp_a, input logic [7:0] exp_res,
                          input logic [3:0] exp_flags, input logic [7:0] exp_acc);
        wait_cmd_ready(name);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tests++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_exec_hs: cmd_ready=%b rsp_valid=%b want 0 0", name, cmd_ready, rsp_valid);
        end
        tests++;
        if (add_a !== exp_a || add_b !== data || add_cin !== op[1]) begin
            fails++;
            $display("FAIL %s_drive: a=%02h b=%02h cin=%b want a=%02h b=%02h cin=%b",
                     name, add_a, add_b, add_cin, exp_a, data, op[1]);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_res || rsp_flags !== exp_flags) begin
            fails++;
            $display("FAIL %s_rsp: valid=%b data=%02h flags=%04b want 1 %02h %04b",
                     name, rsp_valid, rsp_data, rsp_flags, exp_res, exp_flags);
        end
        tests++;
        if (acc_out !== exp_acc) begin
            fails++;
            $display("FAIL %s_acc: acc=%02h want %02h", name, acc_out, exp_acc);
        end
        $display("[TB] %s op=%0d data=%02h -> rsp=%02h flags=%04b acc=%02h",
                 name, op, data, rsp_data, rsp_flags, acc_out);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: rsp_valid=%b cmd_ready=%b want 0 1", name, rsp_valid, cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || acc_out !== 8'h00 ||
            rsp_data !== 8'h00 || rsp_flags !== 4'b0000) begin
            fails++;
            $display("FAIL reset_state: rsp_valid=%b cmd_ready=%b acc=%02h data=%02h flags=%04b",
                     rsp_valid, cmd_ready, acc_out, rsp_data, rsp_flags);
        end
        tests++;
        if (add_a !== 8'h00 || add_b !== 8'h00 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL reset_drive: a=%02h b=%02h cin=%b want 00 00 0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset released");
    endtask

    task automatic test_reset_mid_resp();
        wait_cmd_ready("mid_rst");
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'hA5;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || acc_out !== 8'hA5) begin
            fails++;
            $display("FAIL mid_rst_pre: rsp_valid=%b acc=%02h want 1 a5", rsp_valid, acc_out);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || acc_out !== 8'h00) begin
            fails++;
            $display("FAIL mid_rst_async: rsp_valid=%b acc=%02h want 0 00", rsp_valid, acc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (cmd_ready !== 1'b1 || acc_out !== 8'h00 || add_a !== 8'h00 ||
            add_b !== 8'h00 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_after: cmd_ready=%b acc=%02h a=%02h b=%02h cin=%b",
                     cmd_ready, acc_out, add_a, add_b, add_cin);
        end
        $display("[TB] reset during RESP");
    endtask

    task automatic test_add();
        run_op("load_7f", OP_LOAD, 8'h7F, 8'h00, 8'h7F, 4'b0000, 8'h7F);
        run_op("add_ovf", OP_ADD,  8'h01, 8'h7F, 8'h80, 4'b0011, 8'h80);
        run_op("load_ff", OP_LOAD, 8'hFF, 8'h80, 8'hFF, 4'b0010, 8'hFF);
        run_op("add_wrap", OP_ADD, 8'h01, 8'hFF, 8'h00, 4'b1100, 8'h00);
    endtask

    task automatic test_sub();
        run_op("load_05", OP_LOAD, 8'h05, 8'h00, 8'h05, 4'b0000, 8'h05);
        run_op("sub_eq",  OP_SUB,  8'h05, 8'h05, 8'h00, 4'b1100, 8'h00);
        run_op("load_00", OP_LOAD, 8'h00, 8'h00, 8'h00, 4'b0100, 8'h00);
        run_op("sub_brw", OP_SUB,  8'h01, 8'h00, 8'hFF, 4'b0010, 8'hFF);
        run_op("load_80", OP_LOAD, 8'h80, 8'hFF, 8'h80, 4'b0010, 8'h80);
        run_op("sub_ovf", OP_SUB,  8'h01, 8'h80, 8'h7F, 4'b1001, 8'h7F);
    endtask

    task automatic test_cmp();
        run_op("load_10", OP_LOAD, 8'h10, 8'h7F, 8'h10, 4'b0000, 8'h10);
        run_op("cmp_20",  OP_CMP,  8'h20, 8'h10, 8'hF0, 4'b0010, 8'h10);
        run_op("add_00",  OP_ADD,  8'h00, 8'h10, 8'h10, 4'b0000, 8'h10);
    endtask

    task automatic test_back_to_back();
        run_op("load_33", OP_LOAD, 8'h33, 8'h10, 8'h33, 4'b0000, 8'h33);
        wait_cmd_ready("bp");
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 8'h11;
        @(posedge clk);
        #1;
        // A new command is presented early and must be ignored until the response leaves.
        cmd_op   = OP_LOAD;
        cmd_data = 8'hAA;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h44 || rsp_flags !== 4'b0000 ||
                cmd_ready !== 1'b0 || acc_out !== 8'h44) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b data=%02h flags=%04b cmd_ready=%b acc=%02h want 1 44 0000 0 44",
                         i, rsp_valid, rsp_data, rsp_flags, cmd_ready, acc_out);
            end
        end
        $display("[TB] backpressure held rsp=%02h flags=%04b for 5 cycles", rsp_data, rsp_flags);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || add_b !== 8'h11) begin
            fails++;
            $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b add_b=%02h want 0 1 11",
                     rsp_valid, cmd_ready, add_b);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        tests++;
        if (cmd_ready !== 1'b0 || add_b !== 8'hAA || add_cin !== 1'b0 || acc_out !== 8'h44) begin
            fails++;
            $display("FAIL bp_accept: cmd_ready=%b add_b=%02h cin=%b acc=%02h want 0 aa 0 44",
                     cmd_ready, add_b, add_cin, acc_out);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'hAA || rsp_flags !== 4'b0010 || acc_out !== 8'hAA) begin
            fails++;
            $display("FAIL bp_next_rsp: valid=%b data=%02h flags=%04b acc=%02h want 1 aa 0010 aa",
                     rsp_valid, rsp_data, rsp_flags, acc_out);
        end
        $display("[TB] queued load -> rsp=%02h flags=%04b acc=%02h", rsp_data, rsp_flags, acc_out);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        test_reset();
        test_reset_mid_resp();
        test_add();
        test_sub();
        test_cmp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
